nmea_time_tx: RTL

NMEA_TIME_TX -- requirements
Module: nmea_time_tx

---
 rtl/nmea_pkg.sv | 74 +++++++
 rtl/uart_tx_byte.sv | 76 +++++++
 rtl/nmea_time_tx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/nmea_pkg.sv
// Shared constants, FSM state type and time/ASCII helpers for the NMEA time transmitter.
// Optional feature macro: NMEA_CHECKSUM_EN (adds the "*CS" field constants and hex helper).
package nmea_pkg;

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_G      = 8'h47;
   localparam logic [7:0] CH_P      = 8'h50;
   localparam logic [7:0] CH_A      = 8'h41;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_ZERO   = 8'h30;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;

`ifdef NMEA_CHECKSUM_EN
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [4:0] SENT_LEN  = 5'd21;
   localparam logic [4:0] CS_FIRST  = 5'd1;
   localparam logic [4:0] CS_LAST   = 5'd15;
`else
   localparam logic [4:0] SENT_LEN  = 5'd18;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Time is packed as {hh[4:0], mm[5:0], ss[5:0]}.
   function automatic logic [16:0] time_inc(input logic [16:0] t);
      logic [4:0] hh;
      logic [5:0] mm;
      logic [5:0] ss;
      hh = t[16:12];
      mm = t[11:6];
      ss = t[5:0];
      if (ss == 6'd59) begin
         ss = 6'd0;
         if (mm == 6'd59) begin
            mm = 6'd0;
            if (hh == 5'd23) hh = 5'd0;
            else             hh = hh + 5'd1;
         end else begin
            mm = mm + 6'd1;
         end
      end else begin
         ss = ss + 6'd1;
      end
      return {hh, mm, ss};
   endfunction

   function automatic logic [15:0] dec_ascii(input logic [5:0] v);
      logic [2:0] tens;
      logic [5:0] ones;
      if      (v >= 6'd50) tens = 3'd5;
      else if (v >= 6'd40) tens = 3'd4;
      else if (v >= 6'd30) tens = 3'd3;
      else if (v >= 6'd20) tens = 3'd2;
      else if (v >= 6'd10) tens = 3'd1;
      else                 tens = 3'd0;
      ones = v - ({3'b000, tens} * 6'd10);
      return {CH_ZERO + {5'b00000, tens}, CH_ZERO + {2'b00, ones}};
   endfunction

`ifdef NMEA_CHECKSUM_EN
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10) return CH_ZERO + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; each bit lasts CLK_DIV+1 clocks. ready rises in the last
// cycle of the stop bit so a queued byte starts with no idle gap.
module uart_tx_byte #(
   parameter int CLK_DIV = 355
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_in,
   input  logic       valid,
   output logic       ready,
   output logic       txd
);

   localparam int CW = $clog2(CLK_DIV + 2);
   localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          active_q, active_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [9:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic          bit_end_s;

   // Bit timer and shift register; the line register always holds the current bit.
   always_comb begin
      active_d  = active_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      txd_d     = txd_q;
      bit_end_s = active_q && (cnt_q == DIV_MAX);
      ready     = !active_q || (bit_end_s && (bit_q == 4'd9));
      if (valid && ready) begin
         active_d = 1'b1;
         cnt_d    = '0;
         bit_d    = 4'd0;
         shift_d  = {1'b1, byte_in, 1'b0};
         txd_d    = 1'b0;
      end else if (bit_end_s) begin
         cnt_d = '0;
         if (bit_q == 4'd9) begin
            active_d = 1'b0;
            txd_d    = 1'b1;
         end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = {1'b1, shift_q[9:1]};
            txd_d   = shift_q[1];
         end
      end else if (active_q) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Serialiser state; reset parks the line high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         bit_q    <= 4'd0;
         shift_q  <= 10'h3FF;
         txd_q    <= 1'b1;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
      end
   end

   assign txd = txd_q;

endmodule

// File: rtl/nmea_time_tx.sv
// PPS-driven time-of-day counter that transmits a $GPGGA time sentence on each second.
// Optional: define NMEA_CHECKSUM_EN to append "*CS" (XOR checksum, two hex digits).
module nmea_time_tx
   import nmea_pkg::*;
#(
   parameter int CLK_DIV = 355
) (
   input  logic       SYS_CLK,
   input  logic       SYS_RST_N,
   input  logic       pps_in,
   input  logic       set_valid,
   input  logic [4:0] set_hh,
   input  logic [5:0] set_mm,
   input  logic [5:0] set_ss,
   output logic       uart_txd,
   output logic       busy,
   output logic       sent,
   output logic       overrun,
   output logic [4:0] cur_hh,
   output logic [5:0] cur_mm,
   output logic [5:0] cur_ss
);

   logic        pps_s1_q, pps_s2_q, pps_s3_q;
   logic        pps_rise_s, load_ok_s;
   logic [16:0] base_s;
   logic [16:0] time_q, time_d;
   logic [16:0] snap_q, snap_d;
   state_e      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic        busy_q, busy_d, sent_q, sent_d, overrun_q, overrun_d;
   logic [7:0]  tx_byte_s;
   logic        tx_valid_s, tx_ready_s;
   logic [15:0] hh_a_s, mm_a_s, ss_a_s;
`ifdef NMEA_CHECKSUM_EN
   logic [7:0]  cs_q, cs_d;
`endif

   // Time update: a valid load replaces the base value, a PPS edge then adds one second.
   always_comb begin
      pps_rise_s = pps_s2_q && !pps_s3_q;
      load_ok_s  = set_valid && (set_hh <= 5'd23) && (set_mm <= 6'd59) && (set_ss <= 6'd59);
      base_s     = load_ok_s ? {set_hh, set_mm, set_ss} : time_q;
      time_d     = pps_rise_s ? time_inc(base_s) : base_s;
   end

   // Sentence sequencer: the snapshot is taken as the PPS edge is accepted.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      snap_d     = snap_q;
      sent_d     = 1'b0;
      tx_valid_s = 1'b0;
`ifdef NMEA_CHECKSUM_EN
      cs_d       = cs_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pps_rise_s) begin
               snap_d  = time_d;
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            idx_d   = 5'd0;
`ifdef NMEA_CHECKSUM_EN
            cs_d    = 8'h00;
`endif
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (idx_q < SENT_LEN) begin
               tx_valid_s = 1'b1;
               if (tx_ready_s) begin
                  idx_d = idx_q + 5'd1;
`ifdef NMEA_CHECKSUM_EN
                  if ((idx_q >= CS_FIRST) && (idx_q <= CS_LAST)) cs_d = cs_q ^ tx_byte_s;
                  else                                           cs_d = cs_q;
`endif
               end else begin
                  idx_d = idx_q;
               end
            end else if (tx_ready_s) begin
               sent_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d    = (state_d != ST_IDLE);
      overrun_d = pps_rise_s && (state_q != ST_IDLE);
   end

   // Character generator for the current sentence position.
   always_comb begin
      hh_a_s    = dec_ascii({1'b0, snap_q[16:12]});
      mm_a_s    = dec_ascii(snap_q[11:6]);
      ss_a_s    = dec_ascii(snap_q[5:0]);
      tx_byte_s = CH_CR;
      case (idx_q)
         5'd0:    tx_byte_s = CH_DOLLAR;
         5'd1:    tx_byte_s = CH_G;
         5'd2:    tx_byte_s = CH_P;
         5'd3:    tx_byte_s = CH_G;
         5'd4:    tx_byte_s = CH_G;
         5'd5:    tx_byte_s = CH_A;
         5'd6:    tx_byte_s = CH_COMMA;
         5'd7:    tx_byte_s = hh_a_s[15:8];
         5'd8:    tx_byte_s = hh_a_s[7:0];
         5'd9:    tx_byte_s = mm_a_s[15:8];
         5'd10:   tx_byte_s = mm_a_s[7:0];
         5'd11:   tx_byte_s = ss_a_s[15:8];
         5'd12:   tx_byte_s = ss_a_s[7:0];
         5'd13:   tx_byte_s = CH_DOT;
         5'd14:   tx_byte_s = CH_ZERO;
         5'd15:   tx_byte_s = CH_ZERO;
`ifdef NMEA_CHECKSUM_EN
         5'd16:   tx_byte_s = CH_STAR;
         5'd17:   tx_byte_s = hex_ascii(cs_q[7:4]);
         5'd18:   tx_byte_s = hex_ascii(cs_q[3:0]);
         5'd19:   tx_byte_s = CH_CR;
         5'd20:   tx_byte_s = CH_LF;
`else
         5'd16:   tx_byte_s = CH_CR;
         5'd17:   tx_byte_s = CH_LF;
`endif
         default: tx_byte_s = CH_CR;
      endcase
   end

   // All state registers; reset aborts any sentence and clears the synchroniser.
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         pps_s1_q  <= 1'b0;
         pps_s2_q  <= 1'b0;
         pps_s3_q  <= 1'b0;
         time_q    <= 17'd0;
         snap_q    <= 17'd0;
         state_q   <= ST_IDLE;
         idx_q     <= 5'd0;
         busy_q    <= 1'b0;
         sent_q    <= 1'b0;
         overrun_q <= 1'b0;
`ifdef NMEA_CHECKSUM_EN
         cs_q      <= 8'h00;
`endif
      end else begin
         pps_s1_q  <= pps_in;
         pps_s2_q  <= pps_s1_q;
         pps_s3_q  <= pps_s2_q;
         time_q    <= time_d;
         snap_q    <= snap_d;
         state_q   <= state_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
         sent_q    <= sent_d;
         overrun_q <= overrun_d;
`ifdef NMEA_CHECKSUM_EN
         cs_q      <= cs_d;
`endif
      end
   end

   uart_tx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_uart (
      .clk     (SYS_CLK),
      .rst_n   (SYS_RST_N),
      .byte_in (tx_byte_s),
      .valid   (tx_valid_s),
      .ready   (tx_ready_s),
      .txd     (uart_txd)
   );

   assign busy    = busy_q;
   assign sent    = sent_q;
   assign overrun = overrun_q;
   assign cur_hh  = time_q[16:12];
   assign cur_mm  = time_q[11:6];
   assign cur_ss  = time_q[5:0];

endmodule
